// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply MAC sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int DW_DEF = 8;
    localparam int SW_DEF = 20;
    // 16 * 255 * 255 = 1040400 still fits the 20-bit accumulator
    localparam int N_MAX  = 16;

    // Index width for 0..n-1, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Row-major address width for an n x n matrix, never narrower than one bit
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n * n);
    endfunction

    function automatic bit n_legal(input int n);
        return (n >= 1) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k loop counters: k walks the dot product, j/i walk the C elements.
module matmul_idx_cnt
    import matmul_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_inc_k,
    input  logic          i_inc_ij,
    output logic [IW-1:0] o_i,
    output logic [IW-1:0] o_j,
    output logic [IW-1:0] o_k,
    output logic          o_k_last,
    output logic          o_elem_last
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] r_i, r_j, r_k;

    // Element advance restarts k and steps j, carrying into i; otherwise k steps
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_inc_ij) begin
            r_k <= '0;
            if (r_j == LAST) begin
                r_j <= '0;
                r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end else if (i_inc_k) begin
            r_k <= r_k + 1'b1;
        end
    end

    assign o_i         = r_i;
    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_k_last    = (r_k == LAST);
    assign o_elem_last = (r_i == LAST) && (r_j == LAST);

endmodule

// File: rtl/matmul_mac_sched.sv
// Sequences C = A x B through one shared MAC: issues operand reads, gates
// operands into the accumulator, clears it per element and writes results.
module matmul_mac_sched
    import matmul_pkg::*;
#(
    parameter  int N  = 2,
    parameter  int DW = DW_DEF,
    parameter  int SW = SW_DEF,
    localparam int IW = idx_w(N),
    localparam int AW = addr_w(N)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_a_addr,
    output logic [AW-1:0] o_b_addr,
    input  logic [DW-1:0] i_a_rdata,
    input  logic [DW-1:0] i_b_rdata,
    output logic [DW-1:0] o_mac_ain,
    output logic [DW-1:0] o_mac_bin,
    output logic          o_mac_en,
    output logic          o_mac_clr,
    input  logic [SW-1:0] i_mac_sum,
    output logic          o_c_wr_en,
    output logic [AW-1:0] o_c_wr_addr,
    output logic [SW-1:0] o_c_wr_data
);

    if (!n_legal(N)) begin : g_n_check
        $error("matmul_mac_sched: N=%0d outside 1..%0d", N, N_MAX);
    end

    state_t        r_state, w_state_nxt;
    logic          r_valid_q;
    logic [IW-1:0] w_i, w_j, w_k;
    logic          w_k_last, w_elem_last;
    logic          w_cnt_clr, w_inc_k, w_inc_ij, w_acc_clr, w_addr_en, w_wr;

    matmul_idx_cnt #(.N(N), .IW(IW)) u_idx (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clr       (w_cnt_clr),
        .i_inc_k     (w_inc_k),
        .i_inc_ij    (w_inc_ij),
        .o_i         (w_i),
        .o_j         (w_j),
        .o_k         (w_k),
        .o_k_last    (w_k_last),
        .o_elem_last (w_elem_last)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Read data lands one cycle after its address, so MAC enable trails RUN by one
    always_ff @(posedge i_clock) begin
        if (i_reset) r_valid_q <= 1'b0;
        else         r_valid_q <= (r_state == S_RUN);
    end

    // Next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_inc_k     = 1'b0;
        w_inc_ij    = 1'b0;
        w_acc_clr   = 1'b0;
        w_addr_en   = 1'b0;
        w_wr        = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_acc_clr   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_addr_en = 1'b1;
                if (w_k_last) w_state_nxt = S_FLUSH;
                else          w_inc_k     = 1'b1;
            end
            S_FLUSH: w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_wr        = 1'b1;
                w_acc_clr   = 1'b1;
                w_inc_ij    = 1'b1;
                w_state_nxt = w_elem_last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_a_addr    = w_addr_en ? AW'(w_i) * AW'(N) + AW'(w_k) : '0;
    assign o_b_addr    = w_addr_en ? AW'(w_k) * AW'(N) + AW'(w_j) : '0;
    assign o_mac_en    = r_valid_q;
    assign o_mac_ain   = r_valid_q ? i_a_rdata : '0;
    assign o_mac_bin   = r_valid_q ? i_b_rdata : '0;
    assign o_mac_clr   = i_reset | w_acc_clr;
    // A reset landing on a WRITE cycle must not leak a write out
    assign o_c_wr_en   = w_wr & ~i_reset;
    assign o_c_wr_addr = AW'(w_i) * AW'(N) + AW'(w_j);
    assign o_c_wr_data = i_mac_sum;

endmodule

// File: tb/tb_matmul_mac_sched.sv
// Directed bench for matmul_mac_sched: N=2 and N=1 instances, each with
// registered operand memories and a behavioural accumulator.
module tb_matmul_mac_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, st2, st1;

    // ---------------- N=2 instance and environment ----------------
    logic [7:0]  A2 [4];
    logic [7:0]  B2 [4];
    logic [1:0]  aa2, ba2, ca2;
    logic [7:0]  ard2, brd2, ain2, bin2;
    logic        en2, clr2, busy2, done2, wr2;
    logic [19:0] sum2, cd2;

    matmul_mac_sched #(.N(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_start(st2),
        .o_busy(busy2), .o_done(done2),
        .o_a_addr(aa2), .o_b_addr(ba2),
        .i_a_rdata(ard2), .i_b_rdata(brd2),
        .o_mac_ain(ain2), .o_mac_bin(bin2),
        .o_mac_en(en2), .o_mac_clr(clr2), .i_mac_sum(sum2),
        .o_c_wr_en(wr2), .o_c_wr_addr(ca2), .o_c_wr_data(cd2)
    );

    always @(posedge clk) begin
        ard2 <= A2[aa2];
        brd2 <= B2[ba2];
        if (clr2)     sum2 <= '0;
        else if (en2) sum2 <= sum2 + 20'(ain2) * 20'(bin2);
    end

    // ---------------- N=1 instance and environment ----------------
    logic [7:0]  A1 [2];
    logic [7:0]  B1 [2];
    logic        aa1, ba1, ca1;
    logic [7:0]  ard1, brd1, ain1, bin1;
    logic        en1, clr1, busy1, done1, wr1;
    logic [19:0] sum1, cd1;

    matmul_mac_sched #(.N(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(st1),
        .o_busy(busy1), .o_done(done1),
        .o_a_addr(aa1), .o_b_addr(ba1),
        .i_a_rdata(ard1), .i_b_rdata(brd1),
        .o_mac_ain(ain1), .o_mac_bin(bin1),
        .o_mac_en(en1), .o_mac_clr(clr1), .i_mac_sum(sum1),
        .o_c_wr_en(wr1), .o_c_wr_addr(ca1), .o_c_wr_data(cd1)
    );

    always @(posedge clk) begin
        ard1 <= A1[aa1];
        brd1 <= B1[ba1];
        if (clr1)     sum1 <= '0;
        else if (en1) sum1 <= sum1 + 20'(ain1) * 20'(bin1);
    end

    // ---------------- checking ----------------
    int nvec = 0;
    int nmis = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h (%0d), want 0x%0h (%0d)", nm, act, act, exp, exp);
        end
    endtask

    // Per-cycle record of the N=2 instance over one run
    int     wc[$];
    longint wa[$];
    longint wd[$];
    int     dc[$];
    bit     bq[$];
    int     gerr;

    task automatic load2(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
        A2[0] = a0; A2[1] = a1; A2[2] = a2; A2[3] = a3;
        B2[0] = b0; B2[1] = b1; B2[2] = b2; B2[3] = b3;
    endtask

    // Run ncyc cycles on the N=2 instance; start pulses on cycle 0 or is held
    task automatic run2(input int ncyc, input bit hold);
        wc.delete(); wa.delete(); wd.delete(); dc.delete(); bq.delete();
        gerr = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            st2 = hold ? 1'b1 : (c == 0);
            #1;
            bq.push_back(busy2);
            if (wr2) begin
                wc.push_back(c);
                wa.push_back(longint'(ca2));
                wd.push_back(longint'(cd2));
            end
            if (done2) dc.push_back(c);
            if (!en2 && (ain2 != 8'd0 || bin2 != 8'd0)) gerr++;
        end
        @(negedge clk);
        st2 = 1'b0;
    endtask

    typedef struct {
        logic        busy, done, wr, clr, en;
        logic [1:0]  addr;
        logic [19:0] data;
    } vec_t;

    vec_t tv [19];

    function automatic vec_t mk(input logic b, d, w, cl, e, input logic [1:0] a,
                                input logic [19:0] dat);
        vec_t v;
        v.busy = b; v.done = d; v.wr = w; v.clr = cl; v.en = e; v.addr = a; v.data = dat;
        return v;
    endfunction

    initial begin
        //            busy done wr clr en addr data
        tv[0]  = mk(0, 0, 0, 1, 0, 0, 0);
        tv[1]  = mk(1, 0, 0, 0, 0, 0, 0);
        tv[2]  = mk(1, 0, 0, 0, 1, 0, 0);
        tv[3]  = mk(1, 0, 0, 0, 1, 0, 0);
        tv[4]  = mk(1, 0, 1, 1, 0, 0, 19);
        tv[5]  = mk(1, 0, 0, 0, 0, 0, 0);
        tv[6]  = mk(1, 0, 0, 0, 1, 0, 0);
        tv[7]  = mk(1, 0, 0, 0, 1, 0, 0);
        tv[8]  = mk(1, 0, 1, 1, 0, 1, 22);
        tv[9]  = mk(1, 0, 0, 0, 0, 0, 0);
        tv[10] = mk(1, 0, 0, 0, 1, 0, 0);
        tv[11] = mk(1, 0, 0, 0, 1, 0, 0);
        tv[12] = mk(1, 0, 1, 1, 0, 2, 43);
        tv[13] = mk(1, 0, 0, 0, 0, 0, 0);
        tv[14] = mk(1, 0, 0, 0, 1, 0, 0);
        tv[15] = mk(1, 0, 0, 0, 1, 0, 0);
        tv[16] = mk(1, 0, 1, 1, 0, 3, 50);
        tv[17] = mk(1, 1, 0, 0, 0, 0, 0);
        tv[18] = mk(0, 0, 0, 0, 0, 0, 0);

        load2(1, 2, 3, 4, 5, 6, 7, 8);
        A1[0] = 200; A1[1] = 0; B1[0] = 3; B1[1] = 0;
        st2 = 1'b0; st1 = 1'b0; rst = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check("reset outs n2", longint'({busy2, done2, wr2, en2, aa2, ba2}), 0);
        check("reset clr n2", longint'(clr2), 1);
        check("reset outs n1", longint'({busy1, done1, wr1, en1, clr1}), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle clr low", longint'(clr2), 0);

        // ---- table-driven N=2 job ----
        for (int c = 0; c < 19; c++) begin
            logic [27:0] act, exp;
            logic        gok;
            @(negedge clk);
            st2 = (c == 0);
            #1;
            gok = en2 || (ain2 == 8'd0 && bin2 == 8'd0);
            act = {busy2, done2, wr2, clr2, en2, gok,
                   ({2{tv[c].wr}} & ca2), ({20{tv[c].wr}} & cd2)};
            exp = {tv[c].busy, tv[c].done, tv[c].wr, tv[c].clr, tv[c].en, 1'b1,
                   tv[c].addr, tv[c].data};
            check($sformatf("job1 cycle%0d", c), longint'(act), longint'(exp));
            // operand addresses: C00 k=1, C01 k=1, C11 k=0
            if (c == 2)  check("addr c2",  longint'({aa2, ba2}), longint'({2'd1, 2'd2}));
            if (c == 6)  check("addr c6",  longint'({aa2, ba2}), longint'({2'd1, 2'd3}));
            if (c == 13) check("addr c13", longint'({aa2, ba2}), longint'({2'd2, 2'd1}));
        end

        // ---- all operands 255: no wrap ----
        load2(255, 255, 255, 255, 255, 255, 255, 255);
        run2(19, 1'b0);
        check("max nwrites", longint'(wc.size()), 4);
        for (int n = 0; n < wc.size() && n < 4; n++) begin
            check($sformatf("max data%0d", n), wd[n], 130050);
            check($sformatf("max addr%0d", n), wa[n], n);
        end
        check("max gating", longint'(gerr), 0);

        // ---- start held high: back-to-back jobs, no extra writes ----
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        run2(36, 1'b1);
        check("hold nwrites", longint'(wc.size()), 8);
        for (int n = 0; n < wc.size() && n < 8; n++) begin
            int     ecyc [8] = '{4, 8, 12, 16, 22, 26, 30, 34};
            longint edat [4] = '{19, 22, 43, 50};
            check($sformatf("hold wcyc%0d", n), longint'(wc[n]), longint'(ecyc[n]));
            check($sformatf("hold wdat%0d", n), wd[n], edat[n % 4]);
        end
        check("hold ndone", longint'(dc.size()), 2);
        if (dc.size() == 2) check("hold done cyc", longint'(dc[1]), 35);
        check("hold busy c18", longint'(bq[18]), 0);
        check("hold busy c19", longint'(bq[19]), 1);
        check("hold gating", longint'(gerr), 0);

        // ---- reset at cycle 6 of a job ----
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            st2 = (c == 0);
            rst = (c == 6);
        end
        begin
            int nwr = 0;
            int nbusy = 0;
            for (int c = 7; c < 27; c++) begin
                @(negedge clk);
                rst = 1'b0;
                #1;
                if (c == 7) check("rst busy c7", longint'(busy2), 0);
                if (wr2 || done2) nwr++;
                if (busy2) nbusy++;
            end
            check("rst no writes", longint'(nwr), 0);
            check("rst stays idle", longint'(nbusy), 0);
        end
        run2(19, 1'b0);
        check("post-rst nwrites", longint'(wc.size()), 4);
        for (int n = 0; n < wc.size() && n < 4; n++) begin
            longint edat [4] = '{19, 22, 43, 50};
            check($sformatf("post-rst data%0d", n), wd[n], edat[n]);
        end
        check("post-rst done", longint'(dc.size() == 1 && dc[0] == 17), 1);

        // ---- N=1: A=[200], B=[3] ----
        begin
            int nw = 0, wcyc = -1, dcyc = -1, g1 = 0;
            longint wdat = 0;
            bit b5 = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                st1 = (c == 0);
                #1;
                if (wr1) begin
                    nw++; wcyc = c; wdat = longint'(cd1);
                    check("n1 waddr", longint'(ca1), 0);
                end
                if (done1) dcyc = c;
                if (c == 5) b5 = busy1;
                if (!en1 && (ain1 != 8'd0 || bin1 != 8'd0)) g1++;
            end
            st1 = 1'b0;
            check("n1 nwrites", longint'(nw), 1);
            check("n1 wcycle", longint'(wcyc), 3);
            check("n1 wdata", wdat, 600);
            check("n1 done cyc", longint'(dcyc), 4);
            check("n1 idle c5", longint'(b5), 0);
            check("n1 gating", longint'(g1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
